// File: rtl/warp_issue_arbiter_if.sv
// Issue-path bundle for the warp issue arbiter.
// The arbiter side uses the master modport. The launch/readiness/downstream side uses the slave modport.
interface warp_issue_arbiter_if #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_ID_W = 2,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic [NUM_WARPS-1:0] active_init;
    logic [NUM_WARPS-1:0] ready_warps;
    logic                 issue_ready;
    logic                 halt_in;
    logic [WARP_ID_W-1:0] select_warp;
    logic                 issue_valid;
    logic                 busy_en;
    logic [NUM_WARPS-1:0] pc_advance;
    logic [NUM_WARPS-1:0] active_warps;
    logic                 all_done;
    logic [CNT_WIDTH-1:0] issue_count;

    modport master (
        input  start, active_init, ready_warps, issue_ready, halt_in,
        output select_warp, issue_valid, busy_en, pc_advance,
               active_warps, all_done, issue_count
    );

    modport slave (
        output start, active_init, ready_warps, issue_ready, halt_in,
        input  select_warp, issue_valid, busy_en, pc_advance,
               active_warps, all_done, issue_count
    );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Round-robin issue scheduler for the compute unit's warps.
// It picks one ready, active warp and holds it on a valid/ready handshake.
// It pulses the scoreboard busy-set and the warp's PC advance on acceptance.
// It retires warps on HALT and reports when every warp has finished.
module warp_issue_arbiter #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_ID_W = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    warp_issue_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [WARP_ID_W-1:0] r_rr_ptr;
    logic [WARP_ID_W-1:0] r_select;
    logic                 r_valid;
    logic [NUM_WARPS-1:0] r_active;
    logic                 r_all_done;
    logic [CNT_WIDTH-1:0] r_count;

    logic [NUM_WARPS-1:0] w_eligible;
    logic                 w_pick_found;
    logic [WARP_ID_W-1:0] w_pick;
    logic [WARP_ID_W-1:0] w_idx;
    logic                 w_handshake;
    logic [NUM_WARPS-1:0] w_onehot;
    logic [NUM_WARPS-1:0] w_active_after;

    assign w_eligible     = r_active & bus.ready_warps;
    assign w_handshake    = r_valid & bus.issue_ready;
    assign w_onehot       = {{(NUM_WARPS-1){1'b0}}, 1'b1} << r_select;
    assign w_active_after = bus.halt_in ? (r_active & ~w_onehot) : r_active;

    // Rotating priority search: first eligible warp at or after the round-robin pointer
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = r_rr_ptr;
        w_idx        = r_rr_ptr;
        for (int k = 0; k < NUM_WARPS; k++) begin
            w_idx = r_rr_ptr + WARP_ID_W'(k);
            if (!w_pick_found && w_eligible[w_idx]) begin
                w_pick_found = 1'b1;
                w_pick       = w_idx;
            end
        end
    end

    // Launch, arbitrate, hold the committed warp until accepted, retire on HALT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_select   <= '0;
            r_valid    <= 1'b0;
            r_active   <= '0;
            r_all_done <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_active <= bus.active_init;
                        r_count  <= '0;
                        r_rr_ptr <= '0;
                        r_valid  <= 1'b0;
                        if (bus.active_init == '0) begin
                            r_state    <= S_DONE;
                            r_all_done <= 1'b1;
                        end else begin
                            r_state    <= S_ARB;
                            r_all_done <= 1'b0;
                        end
                    end
                end
                S_ARB: begin
                    if (w_pick_found) begin
                        r_select <= w_pick;
                        r_valid  <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_handshake) begin
                        r_valid  <= 1'b0;
                        r_rr_ptr <= r_select + 1'b1;
                        if (!(&r_count)) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_active <= w_active_after;
                        if (w_active_after == '0) begin
                            r_state    <= S_DONE;
                            r_all_done <= 1'b1;
                        end else begin
                            r_state <= S_ARB;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.select_warp  = r_select;
    assign bus.issue_valid  = r_valid;
    assign bus.active_warps = r_active;
    assign bus.all_done     = r_all_done;
    assign bus.issue_count  = r_count;
    assign bus.busy_en      = w_handshake;
    assign bus.pc_advance   = w_handshake ? w_onehot : '0;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Self-checking bench for warp_issue_arbiter.
// A behavioural reference model tracks which warp should issue and when.
// Directed steps come first, followed by a randomized run.
module tb_warp_issue_arbiter;

    localparam int MODE_IDLE  = 10;
    localparam int MODE_ARB   = 20;
    localparam int MODE_ISSUE = 30;
    localparam int MODE_DONE  = 40;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    warp_issue_arbiter_if #(.NUM_WARPS(4), .WARP_ID_W(2), .CNT_WIDTH(16)) bus ();

    warp_issue_arbiter #(.NUM_WARPS(4), .WARP_ID_W(2), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         mMode;
    logic [3:0] mActive;
    int         mRr;
    int         mSel;
    int         mValid;
    int         mCount;

    int         hsLog[$];
    int         hsCyc[$];
    int         pcLog[$];
    logic [3:0] pcOr;

    function automatic int pickWarp(logic [3:0] elig, int from);
        for (int k = 0; k < 4; k++) begin
            if (elig[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mMode   = MODE_IDLE;
        mActive = 4'b0000;
        mRr     = 0;
        mSel    = 0;
        mValid  = 0;
        mCount  = 0;
    endtask

    task automatic modelClock();
        int p;
        case (mMode)
            MODE_IDLE, MODE_DONE: begin
                if (bus.start === 1'b1) begin
                    mActive = bus.active_init;
                    mCount  = 0;
                    mRr     = 0;
                    mMode   = (bus.active_init == 4'b0000) ? MODE_DONE : MODE_ARB;
                end
            end
            MODE_ARB: begin
                p = pickWarp(mActive & bus.ready_warps, mRr);
                if (p >= 0) begin
                    mSel   = p;
                    mValid = 1;
                    mMode  = MODE_ISSUE;
                end
            end
            MODE_ISSUE: begin
                if (bus.issue_ready === 1'b1) begin
                    mValid = 0;
                    mRr    = (mSel + 1) % 4;
                    if (mCount < 65535) mCount = mCount + 1;
                    if (bus.halt_in === 1'b1) mActive[mSel] = 1'b0;
                    mMode = (mActive == 4'b0000) ? MODE_DONE : MODE_ARB;
                end
            end
            default: mMode = MODE_IDLE;
        endcase
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkRegs();
        checkOutput("select_warp",  32'(bus.select_warp),  32'(mSel));
        checkOutput("issue_valid",  32'(bus.issue_valid),  32'(mValid));
        checkOutput("active_warps", 32'(bus.active_warps), 32'(mActive));
        checkOutput("all_done",     32'(bus.all_done),     (mMode == MODE_DONE) ? 32'd1 : 32'd0);
        checkOutput("issue_count",  32'(bus.issue_count),  32'(mCount));
    endtask

    task automatic checkComb();
        logic hs;
        hs = (mMode == MODE_ISSUE) && (bus.issue_ready === 1'b1);
        checkOutput("busy_en",    32'(bus.busy_en),    hs ? 32'd1 : 32'd0);
        checkOutput("pc_advance", 32'(bus.pc_advance), hs ? (32'd1 << mSel) : 32'd0);
    endtask

    // One clock cycle: drive inputs, check pulses, advance the model, check registered state
    task automatic applyStimulus(logic st, logic [3:0] ai, logic [3:0] rw, logic ir, logic hi);
        bus.start       = st;
        bus.active_init = ai;
        bus.ready_warps = rw;
        bus.issue_ready = ir;
        bus.halt_in     = hi;
        #1;
        checkComb();
        if (bus.busy_en === 1'b1) begin
            hsLog.push_back(int'(bus.select_warp));
            hsCyc.push_back(cyc);
            pcLog.push_back(int'(bus.pc_advance));
            pcOr = pcOr | bus.pc_advance;
        end
        @(posedge clk);
        modelClock();
        @(negedge clk);
        checkRegs();
        cyc++;
    endtask

    task automatic doReset();
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.active_init = 4'b0000;
        bus.ready_warps = 4'b0000;
        bus.issue_ready = 1'b0;
        bus.halt_in     = 1'b0;
        #2;
        modelReset();
        checkRegs();
        checkComb();
        @(negedge clk);
        reset = 1'b0;
        hsLog.delete();
        hsCyc.delete();
        pcLog.delete();
        pcOr = 4'b0000;
    endtask

    // Directed scenarios followed by a randomized run against the model
    initial begin
        int rrExp[5];
        int skipExp[3];
        total = 0;
        bad   = 0;
        cyc   = 0;
        rrExp   = '{0, 1, 2, 3, 0};
        skipExp = '{1, 3, 1};

        doReset();

        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
        checkOutput("rr_hs_count", 32'(hsLog.size()), 32'd5);
        for (int i = 0; i < hsLog.size() && i < 5; i++) begin
            checkOutput("rr_pick", 32'(hsLog[i]), 32'(rrExp[i]));
            checkOutput("rr_pc",   32'(pcLog[i]), 32'd1 << rrExp[i]);
            if (i > 0) checkOutput("rr_spacing", 32'(hsCyc[i] - hsCyc[i-1]), 32'd2);
        end
        checkOutput("rr_issue_count", 32'(bus.issue_count), 32'd5);

        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b0000, 4'b1010, 1'b1, 1'b0);
        checkOutput("skip_hs_count", 32'(hsLog.size()), 32'd4);
        for (int i = 0; i < hsLog.size() && i < 3; i++) begin
            checkOutput("skip_pick", 32'(hsLog[i]), 32'(skipExp[i]));
        end
        checkOutput("skip_never_0_2", 32'(pcOr & 4'b0101), 32'd0);

        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0000, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            checkOutput("bp_hold_sel",   32'(bus.select_warp), 32'd2);
            checkOutput("bp_hold_valid", 32'(bus.issue_valid), 32'd1);
        end
        checkOutput("bp_no_busy", 32'(hsLog.size()), 32'd0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("bp_one_busy", 32'(hsLog.size()), 32'd1);
        if (pcLog.size() > 0) checkOutput("bp_pc", 32'(pcLog[0]), 32'b0100);

        doReset();
        applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1);
        checkOutput("halt_before", 32'(bus.active_warps), 32'b0011);
        applyStimulus(1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1);
        checkOutput("halt_first", 32'(bus.active_warps), 32'b0010);
        applyStimulus(1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1);
        checkOutput("halt_second", 32'(bus.active_warps), 32'b0000);
        checkOutput("halt_done",   32'(bus.all_done),     32'd1);
        checkOutput("halt_count",  32'(bus.issue_count),  32'd2);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
        checkOutput("restart_done",   32'(bus.all_done),     32'd0);
        checkOutput("restart_active", 32'(bus.active_warps), 32'b0001);

        doReset();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("empty_done", 32'(bus.all_done), 32'd1);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
            checkOutput("stall_valid", 32'(bus.issue_valid), 32'd0);
        end

        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 32'(bus.issue_valid), 32'd1);
        checkOutput("pre_rst_count", 32'(bus.issue_count), 32'd1);
        #3;
        reset           = 1'b1;
        bus.issue_ready = 1'b1;
        #1;
        checkOutput("arst_valid",  32'(bus.issue_valid),  32'd0);
        checkOutput("arst_active", 32'(bus.active_warps), 32'd0);
        checkOutput("arst_count",  32'(bus.issue_count),  32'd0);
        checkOutput("arst_busy",   32'(bus.busy_en),      32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        checkRegs();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("arst_idle_start", 32'(bus.all_done), 32'd1);

        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/warp_issue_arbiter.md
Name: warp_issue_arbiter

Overview:
- Round-robin issue scheduler for the compute unit's four warps.
- Each cycle it combines per-warp readiness (from the readiness check) with a per-warp active mask, and picks one warp.
- It presents that warp to the issue path with a valid/ready handshake. On acceptance it pulses the scoreboard busy-set and the selected warp's PC advance.
- It tracks warp retirement (HALT) and signals when all warps have finished.

Parameters:
- NUM_WARPS, 4, number of warps; fixed power of two.
- WARP_ID_W, 2, width of warp index; equals log2(NUM_WARPS).
- CNT_WIDTH, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch pulse; sampled only in IDLE or DONE
- active_init  input  NUM_WARPS  warps participating in the launch; captured on accepted start
- ready_warps  input  NUM_WARPS  per-warp ready, from warp readiness check
- issue_ready  input  1  downstream (decode/LSU) accepts the presented warp
- halt_in  input  1  issued instruction is HALT; sampled only on handshake
- select_warp  output  WARP_ID_W  warp index driving the PC mux and warp_num
- issue_valid  output  1  select_warp holds a committed warp
- busy_en  output  1  one-cycle pulse to the scoreboard: mark the selected warp's threads busy
- pc_advance  output  NUM_WARPS  one-hot, one-cycle pulse to Warp_State: increment that warp's PC
- active_warps  output  NUM_WARPS  current active mask
- all_done  output  1  high in DONE
- issue_count  output  CNT_WIDTH  instructions issued since last accepted start

Behaviour:
- Reset values: state=IDLE; select_warp=0; rr_ptr=0; issue_valid=0; busy_en=0; pc_advance=0; active_warps=0; all_done=0; issue_count=0.
- State encoding: IDLE, ARB, ISSUE, DONE.
- Registered outputs: all outputs are registered except busy_en and pc_advance.
- IDLE:
  - On start: active_warps<=active_init, issue_count<=0, rr_ptr<=0.
  - If active_init==0, go to DONE; else go to ARB.
- ARB:
  - eligible = active_warps & ready_warps.
  - If eligible==0: stay in ARB, with issue_valid=0.
  - Else pick the first eligible warp searching rr_ptr, rr_ptr+1, ... modulo NUM_WARPS (wrap 3->0).
  - Register the pick into select_warp, set issue_valid<=1, go to ISSUE.
- ISSUE:
  - select_warp and issue_valid are held stable until the handshake.
  - ready_warps changes are ignored; the warp is committed.
  - Handshake = issue_valid & issue_ready. Same cycle, combinationally: busy_en=1 and pc_advance[select_warp]=1.
  - On handshake: issue_valid<=0; rr_ptr<=select_warp+1 (mod NUM_WARPS); issue_count<=issue_count+1, saturating at all-ones.
  - If halt_in is also high on handshake: clear active_warps[select_warp].
  - Next state: DONE if the updated active mask is 0, else ARB.
  - busy_en and pc_advance are 0 in every cycle without a handshake.
- Issue timing:
  - Minimum issue interval is 2 cycles: handshake at H, re-arbitrate at H+1, issue_valid at H+2.
  - start at cycle N gives issue_valid at N+2 at the earliest.
- DONE:
  - all_done=1; active_warps=0; issue_count is retained.
  - On start, behave as in IDLE; all_done drops the next cycle.
- start outside IDLE/DONE is ignored.
- halt_in without a handshake is ignored.
- A HALT counts as an issued instruction: busy_en and pc_advance still pulse.
- Reset asserted mid-operation (any state, including a pending ISSUE) forces all reset values immediately. No pulse is emitted.
- Fairness: a continuously eligible warp is issued within NUM_WARPS handshakes.

Test Plan:
- Round-robin: reset, start with active_init=4'b1111, ready_warps=4'b1111, issue_ready=1. Required: select_warp sequence 0,1,2,3,0 on successive handshakes, spaced 2 cycles apart; pc_advance 0001,0010,0100,1000; issue_count=5.
- Skip unready and wrap: ready_warps=4'b1010 with rr_ptr=0. Required: picks 1, then 3, then 1. Warps 0 and 2 never get pc_advance.
- Backpressure: issue_ready=0 for 5 cycles while in ISSUE with warp 2, and ready_warps toggled meanwhile. Required: select_warp stays 2 and issue_valid stays 1; no busy_en. When issue_ready rises: exactly one busy_en and pc_advance=4'b0100.
- Halt and done: active_init=4'b0011; halt_in=1 on the handshakes for warp 0 then warp 1. Required: active_warps 0011->0010->0000; all_done=1 the cycle after the second handshake; issue_count=2. A new start re-enters ARB with all_done=0.
- Empty launch and idle stall: start with active_init=0 gives DONE the next cycle. start with active_init=4'b0001 and ready_warps=0 for 10 cycles gives issue_valid=0 throughout.
- Async reset: assert reset mid-ISSUE, between clock edges. Required: issue_valid, active_warps and issue_count go to 0 without waiting for a clock edge; state is IDLE after release.
